mem_ctrl: RTL

- Memory-access sequencer between the datapath's MAR/MDR and the external word-addressed RAM.
- Accepts a one-cycle Read or Write strobe from the control unit and latches the MAR address and MDR write data.
- Runs a req/ack handshake with RAM, with variable wait states and a timeout.
- Returns read data as Mdatain to the MDR and signals completion with MemDone, or failure with MemErr.

---
 rtl/mem_ctrl_pkg.sv | 20 ++
 rtl/mem_ctrl_if.sv | 32 +++
 rtl/mem_ctrl_wait_counter.sv | 33 +++
 rtl/mem_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and default sizing for the memory-access sequencer and its bench.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_ADDR_W  = 9;
    localparam int unsigned DEF_TIMEOUT = 16;
    localparam int unsigned CNT_W       = 8;

    function automatic logic is_single_req(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Control-unit and RAM-side signal bundle of the memory sequencer.
interface mem_ctrl_if #(
    parameter int unsigned WIDTH  = mem_pkg::DEF_WIDTH,
    parameter int unsigned ADDR_W = mem_pkg::DEF_ADDR_W
);
    logic              Read;
    logic              Write;
    logic [WIDTH-1:0]  MAR;
    logic [WIDTH-1:0]  MDRdata;
    logic [WIDTH-1:0]  Mdatain;
    logic              MemBusy;
    logic              MemDone;
    logic              MemErr;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic              mem_req;
    logic              mem_we;
    logic              mem_ack;
    logic [WIDTH-1:0]  mem_rdata;

    modport master (
        input  Read, Write, MAR, MDRdata, mem_ack, mem_rdata,
        output Mdatain, MemBusy, MemDone, MemErr,
               mem_addr, mem_wdata, mem_req, mem_we
    );

    modport slave (
        output Read, Write, MAR, MDRdata, mem_ack, mem_rdata,
        input  Mdatain, MemBusy, MemDone, MemErr,
               mem_addr, mem_wdata, mem_req, mem_we
    );
endinterface

// File: rtl/mem_ctrl_wait_counter.sv
// Wait-state counter for an outstanding RAM access; flags the last allowed cycle.
module wait_counter
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Count wait cycles, restarting whenever the sequencer is not in an access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (en) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == LAST);

endmodule

// File: rtl/mem_ctrl.sv
// Memory-access sequencer: latches a MAR/MDR request, runs req/ack with RAM, reports done or error.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic       Clock,
    input  logic       Reset,
    mem_ctrl_if.master bus
);

    state_t            state_r;
    logic [WIDTH-1:0]  mdatain_r;
    logic [ADDR_W-1:0] addr_r;
    logic [WIDTH-1:0]  wdata_r;
    logic              we_r;
    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              expired_s;
    logic              unused_mar_hi_s;

    // MAR bits above the RAM address width wrap silently.
    assign unused_mar_hi_s = ^bus.MAR[WIDTH-1:ADDR_W];

    assign cnt_clr_s = (state_r != ACCESS);
    assign cnt_en_s  = (state_r == ACCESS) && !bus.mem_ack;

    wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk     (Clock),
        .rst     (Reset),
        .clr     (cnt_clr_s),
        .en      (cnt_en_s),
        .expired (expired_s)
    );

    // Access sequencer: request latch, handshake, timeout and read-data capture.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r   <= IDLE;
            mdatain_r <= {WIDTH{1'b0}};
            addr_r    <= {ADDR_W{1'b0}};
            wdata_r   <= {WIDTH{1'b0}};
            we_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Read && bus.Write) begin
                        state_r <= ERR;
                    end else if (is_single_req(bus.Read, bus.Write)) begin
                        addr_r  <= bus.MAR[ADDR_W-1:0];
                        wdata_r <= bus.MDRdata;
                        we_r    <= bus.Write;
                        state_r <= ACCESS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // An ack on the timeout cycle still completes the access.
                    if (bus.mem_ack) begin
                        if (!we_r) begin
                            mdatain_r <= bus.mem_rdata;
                        end else begin
                            mdatain_r <= mdatain_r;
                        end
                        state_r <= DONE;
                    end else if (expired_s) begin
                        state_r <= ERR;
                    end else begin
                        state_r <= ACCESS;
                    end
                end
                DONE:    state_r <= IDLE;
                ERR:     state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.Mdatain   = mdatain_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign bus.mem_we    = we_r;
    assign bus.mem_req   = (state_r == ACCESS);
    assign bus.MemBusy   = (state_r != IDLE);
    assign bus.MemDone   = (state_r == DONE);
    assign bus.MemErr    = (state_r == ERR);

endmodule
